bram_tdp_ctrl: RTL and testbench

//  Parametrised true dual-port block RAM with byte-write in every read/write mode, read-valid pipeline and

---
 rtl/bram_tdp_pkg.sv | 32 +++
 rtl/bram_tdp_ctrl_if.sv | 31 +++
 rtl/bram_tdp_rd_pipe.sv | 61 ++++++
 rtl/bram_tdp_ctrl.sv | 148 ++++++++++++++
 tb/tb_bram_tdp_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_tdp_pkg.sv
// Shared definitions for the true dual-port BRAM controller: mode names,
// clear-sequencer state type and width derivation helpers.
package bram_tdp_pkg;

    localparam string RwReadFirst  = "read_first";
    localparam string RwWriteFirst = "write_first";
    localparam string RwNoChange   = "no_change";

    typedef enum logic {StClr, StRun} clr_state_e;

    // Number of bits needed to represent value (0 for value == 0).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned bits = 0;
        int unsigned v    = value;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return bits;
    endfunction

    // Address width; one spare bit so out-of-range addresses are expressible.
    function automatic int unsigned calc_aw(input int unsigned depth);
        return clogb2(depth - 1) + 1;
    endfunction

    // Byte-mask width.
    function automatic int unsigned calc_bw(input int unsigned width, input bit byte_wr);
        return byte_wr ? width / 8 : 1;
    endfunction

endpackage

// File: rtl/bram_tdp_ctrl_if.sv
// Two-port RAM bus: per-port enable/mask/address/data plus status outputs.
interface bram_tdp_ctrl_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 11,
    parameter int unsigned MaskWidth = 4
);
    logic                 ena;
    logic [MaskWidth-1:0] wea;
    logic [AddrWidth-1:0] addra;
    logic [DataWidth-1:0] dina;
    logic [DataWidth-1:0] douta;
    logic                 douta_vld;
    logic                 enb;
    logic [MaskWidth-1:0] web;
    logic [AddrWidth-1:0] addrb;
    logic [DataWidth-1:0] dinb;
    logic [DataWidth-1:0] doutb;
    logic                 doutb_vld;
    logic                 init_done;
    logic                 collision;

    modport master (
        output ena, wea, addra, dina, enb, web, addrb, dinb,
        input  douta, douta_vld, doutb, doutb_vld, init_done, collision
    );

    modport slave (
        input  ena, wea, addra, dina, enb, web, addrb, dinb,
        output douta, douta_vld, doutb, doutb_vld, init_done, collision
    );
endinterface

// File: rtl/bram_tdp_rd_pipe.sv
// Per-port read-data pipeline: capture stage plus optional output register.
// Data holds between reads; valid is a one-cycle pulse per read.
module bram_tdp_rd_pipe #(
    parameter int unsigned Width  = 32,
    parameter bit          OutReg = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rd_en_i,
    input  logic [Width-1:0] rd_data_i,
    output logic [Width-1:0] dout_o,
    output logic             vld_o
);
    logic [Width-1:0] s1_data_q, s1_data_d;
    logic             s1_vld_q, s1_vld_d;

    // First stage next-state: load on read, otherwise hold.
    always_comb begin
        s1_data_d = rd_en_i ? rd_data_i : s1_data_q;
        s1_vld_d  = rd_en_i;
    end

    // First stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    if (OutReg) begin : g_out_reg
        logic [Width-1:0] s2_data_q, s2_data_d;
        logic             s2_vld_q, s2_vld_d;

        // Output stage next-state: take stage-1 data only when it is fresh.
        always_comb begin
            s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
            s2_vld_d  = s1_vld_q;
        end

        // Output stage registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s2_data_q <= '0;
                s2_vld_q  <= 1'b0;
            end else begin
                s2_data_q <= s2_data_d;
                s2_vld_q  <= s2_vld_d;
            end
        end

        assign dout_o = s2_data_q;
        assign vld_o  = s2_vld_q;
    end else begin : g_no_out_reg
        assign dout_o = s1_data_q;
        assign vld_o  = s1_vld_q;
    end
endmodule

// File: rtl/bram_tdp_ctrl.sv
// True dual-port RAM with byte writes, clear-after-reset sequencer,
// same-address collision detection and write-first forwarding across ports.
module bram_tdp_ctrl
    import bram_tdp_pkg::*;
#(
    parameter int unsigned          mem_width           = 32,
    parameter int unsigned          mem_depth           = 1024,
    parameter string                read_write_mode     = "read_first",
    parameter string                use_output_register = "true",
    parameter string                en_byte_write       = "true",
    parameter string                clr_on_rst          = "true",
    parameter logic [mem_width-1:0] clr_value           = '0
) (
    input logic           clk,
    input logic           rst_n,
    bram_tdp_ctrl_if.slave bus
);
    localparam bit          ByteWr   = (en_byte_write == "true");
    localparam bit          OutReg   = (use_output_register == "true");
    localparam bit          ClrRst   = (clr_on_rst == "true");
    localparam bit          WrFirst  = (read_write_mode == RwWriteFirst);
    localparam bit          NoChange = (read_write_mode == RwNoChange);
    localparam int unsigned BW       = calc_bw(mem_width, ByteWr);
    localparam int unsigned LW       = mem_width / BW;
    localparam int unsigned AW       = calc_aw(mem_depth);
    localparam int unsigned IW       = (mem_depth > 1) ? $clog2(mem_depth) : 1;
    localparam logic [AW-1:0] DepthA    = AW'(mem_depth);
    localparam logic [AW-1:0] LastAddr  = AW'(mem_depth - 1);
    localparam clr_state_e    StRst     = ClrRst ? StClr : StRun;

    logic [mem_width-1:0] mem [mem_depth];

    clr_state_e     state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           collision_q, collision_d;

    logic                 run, acc_a, acc_b, in_a, in_b, wr_a, wr_b, same;
    logic                 mem_we_a, mem_we_b, rd_a, rd_b;
    logic [IW-1:0]        idx_a, idx_b;
    logic [mem_width-1:0] old_a, old_b, word_a, word_b, rdata_a, rdata_b;

    assign run   = (state_q == StRun);
    assign in_a  = (bus.addra < DepthA);
    assign in_b  = (bus.addrb < DepthA);
    assign acc_a = run & bus.ena;
    assign acc_b = run & bus.enb;
    assign wr_a  = acc_a & in_a & (|bus.wea);
    assign wr_b  = acc_b & in_b & (|bus.web);
    assign same  = acc_a & acc_b & in_a & (bus.addra == bus.addrb);
    assign idx_a = bus.addra[IW-1:0];
    assign idx_b = bus.addrb[IW-1:0];
    assign old_a = mem[idx_a];
    assign old_b = mem[idx_b];

    // Byte-merged word seen at each port's address; A owns any lane it writes.
    always_comb begin
        word_a = old_a;
        word_b = old_b;
        for (int unsigned i = 0; i < BW; i++) begin
            if (bus.wea[i]) begin
                word_a[i*LW +: LW] = bus.dina[i*LW +: LW];
            end else if (same && wr_b && bus.web[i]) begin
                word_a[i*LW +: LW] = bus.dinb[i*LW +: LW];
            end
            if (same && wr_a && bus.wea[i]) begin
                word_b[i*LW +: LW] = bus.dina[i*LW +: LW];
            end else if (bus.web[i]) begin
                word_b[i*LW +: LW] = bus.dinb[i*LW +: LW];
            end
        end
    end

    // Same-address double write: A's merged word already carries B's lanes.
    assign mem_we_a = wr_a;
    assign mem_we_b = wr_b & ~(same & wr_a);

    // Read selection per mode; out-of-range reads return zero.
    always_comb begin
        rd_a    = acc_a & ~(NoChange & (|bus.wea));
        rd_b    = acc_b & ~(NoChange & (|bus.web));
        rdata_a = in_a ? (WrFirst ? word_a : old_a) : '0;
        rdata_b = in_b ? (WrFirst ? word_b : old_b) : '0;
    end

    // Array writes: clear sequencer owns the array until RUN.
    always_ff @(posedge clk) begin
        if (state_q == StClr) begin
            mem[cnt_q[IW-1:0]] <= clr_value;
        end else begin
            if (mem_we_a) mem[idx_a] <= word_a;
            if (mem_we_b) mem[idx_b] <= word_b;
        end
    end

    // Clear FSM next-state and collision detect.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        collision_d = same & ((|bus.wea) | (|bus.web));
        if (state_q == StClr) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LastAddr) begin
                state_d = StRun;
                cnt_d   = '0;
            end
        end
    end

    // State, clear counter and collision registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRst;
            cnt_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
        end
    end

    assign bus.init_done = run;
    assign bus.collision = collision_q;

    bram_tdp_rd_pipe #(
        .Width (mem_width),
        .OutReg(OutReg)
    ) u_rd_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .rd_en_i  (rd_a),
        .rd_data_i(rdata_a),
        .dout_o   (bus.douta),
        .vld_o    (bus.douta_vld)
    );

    bram_tdp_rd_pipe #(
        .Width (mem_width),
        .OutReg(OutReg)
    ) u_rd_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .rd_en_i  (rd_b),
        .rd_data_i(rdata_b),
        .dout_o   (bus.doutb),
        .vld_o    (bus.doutb_vld)
    );
endmodule

// File: tb/tb_bram_tdp_ctrl.sv
// Bench for bram_tdp_ctrl: three instances (read_first + out reg,
// write_first without out reg, no_change + out reg) driven in lockstep.
module tb_bram_tdp_ctrl;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned BW    = 4;
    localparam int unsigned Depth = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    bram_tdp_ctrl_if #(.DataWidth(DW), .AddrWidth(AW), .MaskWidth(BW)) if_rf ();
    bram_tdp_ctrl_if #(.DataWidth(DW), .AddrWidth(AW), .MaskWidth(BW)) if_wf ();
    bram_tdp_ctrl_if #(.DataWidth(DW), .AddrWidth(AW), .MaskWidth(BW)) if_nc ();

    bram_tdp_ctrl #(
        .mem_width(DW), .mem_depth(Depth), .read_write_mode("read_first"),
        .use_output_register("true"), .en_byte_write("true"), .clr_on_rst("true"),
        .clr_value(32'h0)
    ) u_rf (.clk(clk), .rst_n(rst_n), .bus(if_rf));

    bram_tdp_ctrl #(
        .mem_width(DW), .mem_depth(Depth), .read_write_mode("write_first"),
        .use_output_register("false"), .en_byte_write("true"), .clr_on_rst("true"),
        .clr_value(32'h0)
    ) u_wf (.clk(clk), .rst_n(rst_n), .bus(if_wf));

    bram_tdp_ctrl #(
        .mem_width(DW), .mem_depth(Depth), .read_write_mode("no_change"),
        .use_output_register("true"), .en_byte_write("true"), .clr_on_rst("true"),
        .clr_value(32'h0)
    ) u_nc (.clk(clk), .rst_n(rst_n), .bus(if_nc));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic en, input logic [BW-1:0] we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din);
        if_rf.ena = en; if_rf.wea = we; if_rf.addra = addr; if_rf.dina = din;
        if_wf.ena = en; if_wf.wea = we; if_wf.addra = addr; if_wf.dina = din;
        if_nc.ena = en; if_nc.wea = we; if_nc.addra = addr; if_nc.dina = din;
    endtask

    task automatic set_b(input logic en, input logic [BW-1:0] we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din);
        if_rf.enb = en; if_rf.web = we; if_rf.addrb = addr; if_rf.dinb = din;
        if_wf.enb = en; if_wf.web = we; if_wf.addrb = addr; if_wf.dinb = din;
        if_nc.enb = en; if_nc.web = we; if_nc.addrb = addr; if_nc.dinb = din;
    endtask

    task automatic idle();
        set_a(1'b0, '0, '0, '0);
        set_b(1'b0, '0, '0, '0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] done3();
        return 32'({if_rf.init_done, if_wf.init_done, if_nc.init_done});
    endfunction

    function automatic logic [31:0] vld6();
        return 32'({if_rf.douta_vld, if_rf.doutb_vld, if_wf.douta_vld, if_wf.doutb_vld,
                    if_nc.douta_vld, if_nc.doutb_vld});
    endfunction

    function automatic logic [31:0] coll3();
        return 32'({if_rf.collision, if_wf.collision, if_nc.collision});
    endfunction

    // Port A read: write_first (no out reg) answers after 1 edge, others after 2.
    task automatic read_a(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        set_a(1'b1, '0, addr, '0);
        step();
        set_a(1'b0, '0, '0, '0);
        check_eq($sformatf("rd%0d_wf_vld", addr), 32'(if_wf.douta_vld), 32'h1);
        check_eq($sformatf("rd%0d_wf_data", addr), if_wf.douta, exp);
        check_eq($sformatf("rd%0d_rf_vld_early", addr), 32'(if_rf.douta_vld), 32'h0);
        step();
        check_eq($sformatf("rd%0d_vld_rf_nc_wf", addr),
                 32'({if_rf.douta_vld, if_nc.douta_vld, if_wf.douta_vld}), 32'h6);
        check_eq($sformatf("rd%0d_rf_data", addr), if_rf.douta, exp);
        check_eq($sformatf("rd%0d_nc_data", addr), if_nc.douta, exp);
    endtask

    // Clear runs Depth cycles from release; accesses during it are ignored.
    task automatic clear_wait(input string tag);
        set_a(1'b1, 4'hF, 5'd3, 32'hFFFF_FFFF);
        set_b(1'b1, 4'h0, 5'd3, 32'h0);
        for (int k = 1; k <= int'(Depth); k++) begin
            step();
            check_eq($sformatf("%s_done_c%0d", tag, k), done3(), (k == int'(Depth)) ? 32'h7 : 32'h0);
            check_eq($sformatf("%s_vld_c%0d", tag, k), vld6(), 32'h0);
        end
        idle();
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        repeat (3) step();
        check_eq("rst_init_done", done3(), 32'h0);
        check_eq("rst_vld", vld6(), 32'h0);
        check_eq("rst_coll", coll3(), 32'h0);
        check_eq("rst_douta", if_rf.douta, 32'h0);
        rst_n = 1'b1;
        clear_wait("clr1");
        for (int a = 0; a < int'(Depth); a++) read_a(AW'(a), 32'h0);

        // Full write, then read back.
        set_a(1'b1, 4'hF, 5'd5, 32'hDEAD_BEEF);
        step();
        idle();
        check_eq("wr5_wf_fwd", if_wf.douta, 32'hDEAD_BEEF);
        check_eq("wr5_wf_vld", 32'(if_wf.douta_vld), 32'h1);
        step();
        check_eq("wr5_rf_old", if_rf.douta, 32'h0);
        check_eq("wr5_vld_rf_nc", 32'({if_rf.douta_vld, if_nc.douta_vld}), 32'h2);
        read_a(5'd5, 32'hDEAD_BEEF);

        // Partial byte write; no_change holds its previous output.
        set_a(1'b1, 4'b0011, 5'd5, 32'h0000_1234);
        step();
        idle();
        check_eq("bw5_wf_fwd", if_wf.douta, 32'hDEAD_1234);
        step();
        check_eq("bw5_rf_old", if_rf.douta, 32'hDEAD_BEEF);
        check_eq("bw5_nc_hold", if_nc.douta, 32'hDEAD_BEEF);
        check_eq("bw5_nc_vld", 32'(if_nc.douta_vld), 32'h0);
        read_a(5'd5, 32'hDEAD_1234);

        // Write/write collision, full masks: A wins.
        set_a(1'b1, 4'hF, 5'd7, 32'h1111_1111);
        set_b(1'b1, 4'hF, 5'd7, 32'h2222_2222);
        step();
        idle();
        check_eq("ww_coll", coll3(), 32'h7);
        check_eq("ww_wf_a", if_wf.douta, 32'h1111_1111);
        check_eq("ww_wf_b", if_wf.doutb, 32'h1111_1111);
        step();
        check_eq("ww_coll_pulse", coll3(), 32'h0);
        check_eq("ww_rf_b_old", if_rf.doutb, 32'h0);
        read_a(5'd7, 32'h1111_1111);

        // Write/write collision, A low bytes only.
        set_a(1'b1, 4'b0011, 5'd7, 32'h1111_1111);
        set_b(1'b1, 4'hF, 5'd7, 32'h2222_2222);
        step();
        idle();
        check_eq("wwp_coll", coll3(), 32'h7);
        check_eq("wwp_wf_a", if_wf.douta, 32'h2222_1111);
        check_eq("wwp_wf_b", if_wf.doutb, 32'h2222_1111);
        step();
        check_eq("wwp_rf_a_old", if_rf.douta, 32'h1111_1111);
        read_a(5'd7, 32'h2222_1111);

        // A writes while B reads the same address.
        set_a(1'b1, 4'hF, 5'd9, 32'hAAAA_AAAA);
        step();
        idle();
        step();
        set_a(1'b1, 4'hF, 5'd9, 32'hBBBB_BBBB);
        set_b(1'b1, 4'h0, 5'd9, 32'h0);
        step();
        idle();
        check_eq("wr_coll", coll3(), 32'h7);
        check_eq("wr_wf_b_fwd", if_wf.doutb, 32'hBBBB_BBBB);
        check_eq("wr_wf_b_vld", 32'(if_wf.doutb_vld), 32'h1);
        step();
        check_eq("wr_rf_b_old", if_rf.doutb, 32'hAAAA_AAAA);
        check_eq("wr_nc_b_old", if_nc.doutb, 32'hAAAA_AAAA);
        check_eq("wr_b_vld_rf_nc", 32'({if_rf.doutb_vld, if_nc.doutb_vld}), 32'h3);
        check_eq("wr_nc_a_vld", 32'(if_nc.douta_vld), 32'h0);
        read_a(5'd9, 32'hBBBB_BBBB);

        // Read/read on one address is not a collision.
        set_a(1'b1, 4'h0, 5'd9, 32'h0);
        set_b(1'b1, 4'h0, 5'd9, 32'h0);
        step();
        idle();
        check_eq("rr_coll", coll3(), 32'h0);
        check_eq("rr_wf_b", if_wf.doutb, 32'hBBBB_BBBB);
        step();

        // Independent writes on different addresses; B byte mask.
        set_a(1'b1, 4'hF, 5'd4, 32'h4444_4444);
        set_b(1'b1, 4'b1100, 5'd6, 32'hCCCC_CCCC);
        step();
        idle();
        check_eq("diff_coll", coll3(), 32'h0);
        check_eq("diff_wf_b", if_wf.doutb, 32'hCCCC_0000);
        step();
        read_a(5'd6, 32'hCCCC_0000);

        // Out-of-range write is dropped and must not alias onto address 4.
        set_a(1'b1, 4'hF, 5'd20, 32'h1234_5678);
        step();
        idle();
        check_eq("oor_wf_data", if_wf.douta, 32'h0);
        check_eq("oor_wf_vld", 32'(if_wf.douta_vld), 32'h1);
        step();
        read_a(5'd20, 32'h0);
        read_a(5'd4, 32'h4444_4444);

        // Reset with a read in flight, then reset again mid-clear.
        set_a(1'b1, 4'h0, 5'd5, 32'h0);
        step();
        check_eq("inflight_wf_vld", 32'(if_wf.douta_vld), 32'h1);
        rst_n = 1'b0;
        #1;
        idle();
        check_eq("rst_vld_now", vld6(), 32'h0);
        check_eq("rst_wf_data", if_wf.douta, 32'h0);
        check_eq("rst_done_now", done3(), 32'h0);
        step();
        check_eq("rst_vld_held", vld6(), 32'h0);
        rst_n = 1'b1;
        repeat (5) step();
        check_eq("midclr_done", done3(), 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("midclr_rst_done", done3(), 32'h0);
        step();
        rst_n = 1'b1;
        clear_wait("clr2");
        read_a(5'd3, 32'h0);
        read_a(5'd5, 32'h0);
        read_a(5'd7, 32'h0);
        read_a(5'd9, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
